// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: round-robin arbiter driving a shared inverted-gate latch bank with preset.
// Define LATCH_ARB_VERIFY_EN to add the LATCH_Q readback input and sticky ERR output.
module latch_bank_arbiter #(
   parameter int NREQ        = 4,
   parameter int DW          = 4,
   parameter int GATE_CYCLES = 2,
   parameter int PRE_CYCLES  = 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NREQ-1:0]    REQ,
   input  logic [NREQ*DW-1:0] DATA,
   input  logic               PRE_REQ,
`ifdef LATCH_ARB_VERIFY_EN
   input  logic [DW-1:0]      LATCH_Q,
   output logic               ERR,
`endif
   output logic [NREQ-1:0]    GNT,
   output logic               DONE,
   output logic               BUSY,
   output logic [DW-1:0]      LATCH_D,
   output logic               LATCH_G,
   output logic               LATCH_PRE
);

   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CMAX = (GATE_CYCLES > PRE_CYCLES) ? GATE_CYCLES : PRE_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);
   localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYCLES - 1);
   localparam logic [PW-1:0] SEL_MAX   = PW'(NREQ - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRESET,
      SETUP,
      GATE,
      HOLD
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   sel;
   logic            pre_pending;
   logic            pre_last;
   logic            rr_found;
   logic [PW-1:0]   rr_sel;
   logic [PW-1:0]   idx;
   logic [DW-1:0]   data_arr [NREQ];
   logic [NREQ-1:0] gnt_nxt;
   logic [DW-1:0]   d_nxt;
   logic            done_nxt;
   logic            g_nxt;
   logic            pre_nxt;
   logic            busy_nxt;

   assign pre_last = (state == PRESET) && (cnt == PRE_LAST);

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         data_arr[i] = DATA[i*DW +: DW];
      end
   end

   // First requesting index at or above the pointer, wrapping past NREQ-1.
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = '0;
      idx      = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (!rr_found && REQ[idx]) begin
            rr_found = 1'b1;
            rr_sel   = idx;
         end
      end
   end

   // State register plus the registered outputs and bookkeeping.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         cnt         <= '0;
         ptr         <= '0;
         sel         <= '0;
         pre_pending <= 1'b0;
         GNT         <= '0;
         DONE        <= 1'b0;
         BUSY        <= 1'b0;
         LATCH_D     <= '0;
         LATCH_G     <= 1'b1;
         LATCH_PRE   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         GNT       <= gnt_nxt;
         DONE      <= done_nxt;
         BUSY      <= busy_nxt;
         LATCH_D   <= d_nxt;
         LATCH_G   <= g_nxt;
         LATCH_PRE <= pre_nxt;
         if (state == IDLE && state_nxt == SETUP) begin
            sel <= rr_sel;
         end
         if (state == HOLD) begin
            ptr <= (sel == SEL_MAX) ? '0 : sel + PW'(1);
         end
         if (state == IDLE && pre_pending) begin
            pre_pending <= 1'b0;
         end else if (PRE_REQ) begin
            pre_pending <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (pre_pending) begin
               state_nxt = PRESET;
            end else if (rr_found) begin
               state_nxt = SETUP;
            end
         end
         PRESET: begin
            if (cnt == PRE_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         SETUP: begin
            state_nxt = GATE;
            cnt_nxt   = '0;
         end
         GATE: begin
            if (cnt == GATE_LAST) begin
               state_nxt = HOLD;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         HOLD: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Pin values are derived from the upcoming state so they line up with it.
   always_comb begin
      gnt_nxt  = GNT;
      d_nxt    = LATCH_D;
      done_nxt = (state == HOLD) || pre_last;
      g_nxt    = (state_nxt != GATE);
      pre_nxt  = (state_nxt == PRESET);
      busy_nxt = (state_nxt != IDLE);
      if (state == IDLE && state_nxt == SETUP) begin
         gnt_nxt = NREQ'(1) << rr_sel;
         d_nxt   = data_arr[rr_sel];
      end else if (state == HOLD) begin
         gnt_nxt = '0;
      end
   end

`ifdef LATCH_ARB_VERIFY_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         ERR <= 1'b0;
      end else if ((state == HOLD && LATCH_Q != LATCH_D) || (pre_last && LATCH_Q != '1)) begin
         ERR <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Self-checking bench for latch_bank_arbiter: transaction-level reference model, directed and random stimulus.
// Compiles with or without LATCH_ARB_VERIFY_EN.
module tb_latch_bank_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 4;
   localparam int GC   = 2;
   localparam int PC   = 1;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*DW-1:0] data = '0;
   logic               pre_req = 1'b0;
   logic [NREQ-1:0]    gnt;
   logic               done;
   logic               busy;
   logic [DW-1:0]      latch_d;
   logic               latch_g;
   logic               latch_pre;
`ifdef LATCH_ARB_VERIFY_EN
   logic [DW-1:0]      latch_q = '0;
   logic               err;
   logic               force_q = 1'b0;
   logic               m_err = 1'b0;
`endif

   int n_compared = 0;
   int n_mismatched = 0;

   // Reference model: op 0=idle, 1=write, 2=preset; age counts cycles into the operation.
   int              m_op = 0;
   int              m_age = 0;
   int              m_sel = 0;
   int              m_ptr = 0;
   bit              m_pend = 1'b0;
   logic [DW-1:0]   m_d = '0;
   logic [NREQ-1:0] m_gnt = '0;
   bit              m_done = 1'b0;
   logic [DW-1:0]   bank_q = '0;
   logic [DW-1:0]   prev_d = '0;

   latch_bank_arbiter #(
      .NREQ(NREQ), .DW(DW), .GATE_CYCLES(GC), .PRE_CYCLES(PC)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .REQ(req),
      .DATA(data),
      .PRE_REQ(pre_req),
`ifdef LATCH_ARB_VERIFY_EN
      .LATCH_Q(latch_q),
      .ERR(err),
`endif
      .GNT(gnt),
      .DONE(done),
      .BUSY(busy),
      .LATCH_D(latch_d),
      .LATCH_G(latch_g),
      .LATCH_PRE(latch_pre)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   task automatic modelStep();
      bit fin;
      bit entered_pre;
      fin = (m_op == 1 && m_age == GC + 2) || (m_op == 2 && m_age == PC);
      entered_pre = 1'b0;
      if (rst) begin
         m_op = 0; m_age = 0; m_sel = 0; m_ptr = 0; m_pend = 1'b0;
         m_d = '0; m_gnt = '0; m_done = 1'b0;
`ifdef LATCH_ARB_VERIFY_EN
         m_err = 1'b0;
`endif
      end else begin
`ifdef LATCH_ARB_VERIFY_EN
         if (m_op == 1 && m_age == GC + 2 && latch_q != m_d) m_err = 1'b1;
         if (m_op == 2 && m_age == PC && latch_q != '1) m_err = 1'b1;
`endif
         if (m_op == 0) begin
            if (m_pend) begin
               m_op = 2; m_age = 1; entered_pre = 1'b1;
            end else if (req != '0) begin
               for (int k = NREQ - 1; k >= 0; k--) begin
                  if (req[(m_ptr + k) % NREQ]) m_sel = (m_ptr + k) % NREQ;
               end
               m_op = 1; m_age = 1;
               m_gnt = '0;
               m_gnt[m_sel] = 1'b1;
               m_d = data[m_sel*DW +: DW];
            end
         end else if (fin) begin
            if (m_op == 1) begin
               m_ptr = (m_sel + 1) % NREQ;
               m_gnt = '0;
            end
            m_op = 0; m_age = 0;
         end else begin
            m_age++;
         end
         if (entered_pre) m_pend = 1'b0;
         else if (pre_req) m_pend = 1'b1;
         m_done = fin;
      end
   endtask

   task automatic compareAll();
      bit exp_g;
      exp_g = !(m_op == 1 && m_age >= 2 && m_age <= GC + 1);
      checkOutput("gnt", 32'(gnt), 32'(m_gnt));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("busy", 32'(busy), 32'(m_op != 0));
      checkOutput("latch_d", 32'(latch_d), 32'(m_d));
      checkOutput("latch_g", 32'(latch_g), 32'(exp_g));
      checkOutput("latch_pre", 32'(latch_pre), 32'(m_op == 2));
      checkOutput("g_pre_exclusive", 32'(!latch_g && latch_pre), 32'(0));
      if (!latch_g) checkOutput("d_stable_in_gate", 32'(latch_d), 32'(prev_d));
`ifdef LATCH_ARB_VERIFY_EN
      checkOutput("err", 32'(err), 32'(m_err));
`endif
   endtask

   // One clock: inputs are already stable, model steps on the edge, outputs sampled 1ns later.
   task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d,
                                input logic p, input logic rs);
      req = r; data = d; pre_req = p; rst = rs;
      @(posedge clk);
      modelStep();
      #1;
      compareAll();
      prev_d = latch_d;
      if (latch_pre) bank_q = '1;
      else if (!latch_g) bank_q = latch_d;
`ifdef LATCH_ARB_VERIFY_EN
      latch_q = force_q ? 4'h3 : bank_q;
`endif
   endtask

   function automatic logic [NREQ*DW-1:0] put(input int slot, input logic [DW-1:0] v);
      logic [NREQ*DW-1:0] w;
      w = '0;
      w[slot*DW +: DW] = v;
      return w;
   endfunction

   initial begin
      int done_at;
      int g_low;
      int ngr;
      int ndone;
      int pre_cycles;
      logic [NREQ-1:0] grants [5];
      logic [NREQ-1:0] last_gnt;

      // Reset state
      applyStimulus('0, '0, 1'b0, 1'b1);
      applyStimulus('0, '0, 1'b0, 1'b1);
      checkOutput("rst_latch_g", 32'(latch_g), 32'(1));
      checkOutput("rst_latch_pre", 32'(latch_pre), 32'(0));
      checkOutput("rst_latch_d", 32'(latch_d), 32'(0));
      checkOutput("rst_gnt", 32'(gnt), 32'(0));
      checkOutput("rst_busy", 32'(busy), 32'(0));
      applyStimulus('0, '0, 1'b0, 1'b0);

      // Single write to requester 2
      applyStimulus(4'b0100, put(2, 4'hA), 1'b0, 1'b0);
      checkOutput("w_gnt", 32'(gnt), 32'(4'b0100));
      checkOutput("w_latch_d", 32'(latch_d), 32'(4'hA));
      done_at = 0;
      g_low = 0;
      for (int i = 2; i <= 10; i++) begin
         applyStimulus('0, '0, 1'b0, 1'b0);
         if (!latch_g) g_low++;
         if (done && done_at == 0) done_at = i;
      end
      checkOutput("w_done_latency", 32'(done_at), 32'(GC + 3));
      checkOutput("w_gate_cycles", 32'(g_low), 32'(GC));
      checkOutput("w_bank_q", 32'(bank_q), 32'(4'hA));

      // Round-robin with all requests held
      applyStimulus('0, '0, 1'b0, 1'b1);
      ngr = 0;
      last_gnt = '0;
      for (int i = 0; i < 60 && ngr < 5; i++) begin
         applyStimulus('1, 16'h1234, 1'b0, 1'b0);
         if (gnt != '0 && last_gnt == '0) begin
            grants[ngr] = gnt;
            ngr++;
         end
         last_gnt = gnt;
      end
      checkOutput("rr_grant_count", 32'(ngr), 32'(5));
      checkOutput("rr_grant0", 32'(grants[0]), 32'(4'b0001));
      checkOutput("rr_grant1", 32'(grants[1]), 32'(4'b0010));
      checkOutput("rr_grant2", 32'(grants[2]), 32'(4'b0100));
      checkOutput("rr_grant3", 32'(grants[3]), 32'(4'b1000));
      checkOutput("rr_grant4", 32'(grants[4]), 32'(4'b0001));

      // Preset requested during a write, another write waiting
      applyStimulus('0, '0, 1'b0, 1'b1);
      applyStimulus(4'b0010, put(1, 4'h7), 1'b0, 1'b0);
      applyStimulus(4'b0100, put(2, 4'h9), 1'b1, 1'b0);
      ndone = 0;
      pre_cycles = 0;
      ngr = 0;
      for (int i = 0; i < 30 && ngr == 0; i++) begin
         applyStimulus(4'b0100, put(2, 4'h9), 1'b0, 1'b0);
         if (latch_pre) pre_cycles++;
         if (done) begin
            ndone++;
            if (ndone == 1) checkOutput("pp_bank_after_write", 32'(bank_q), 32'(4'h7));
            if (ndone == 2) checkOutput("pp_bank_after_preset", 32'(bank_q), 32'(4'hF));
         end
         if (ndone == 2 && gnt != '0) begin
            ngr = 1;
            checkOutput("pp_next_grant", 32'(gnt), 32'(4'b0100));
         end
      end
      checkOutput("pp_preset_cycles", 32'(pre_cycles), 32'(PC));
      checkOutput("pp_follow_write_seen", 32'(ngr), 32'(1));

      // DATA change and REQ drop mid-transaction
      applyStimulus('0, '0, 1'b0, 1'b1);
      applyStimulus(4'b0001, put(0, 4'h5), 1'b0, 1'b0);
      applyStimulus(4'b0001, put(0, 4'h5), 1'b0, 1'b0);
      applyStimulus('0, put(0, 4'hC), 1'b0, 1'b0);
      checkOutput("dist_latch_d", 32'(latch_d), 32'(4'h5));
      done_at = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus('0, put(0, 4'hC), 1'b0, 1'b0);
         if (done) done_at = 1;
      end
      checkOutput("dist_done_seen", 32'(done_at), 32'(1));
      checkOutput("dist_bank_q", 32'(bank_q), 32'(4'h5));

      // Reset in the middle of GATE
      applyStimulus(4'b0010, put(1, 4'h6), 1'b0, 1'b0);
      applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("rg_in_gate", 32'(latch_g), 32'(0));
      applyStimulus('0, '0, 1'b0, 1'b1);
      checkOutput("rg_latch_g", 32'(latch_g), 32'(1));
      checkOutput("rg_busy", 32'(busy), 32'(0));
      checkOutput("rg_gnt", 32'(gnt), 32'(0));

`ifdef LATCH_ARB_VERIFY_EN
      // Readback disagrees with the written value
      force_q = 1'b1;
      latch_q = 4'h3;
      applyStimulus(4'b0001, put(0, 4'h5), 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("verr_set", 32'(err), 32'(1));
      force_q = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus('0, '0, 1'b0, 1'b0);
      checkOutput("verr_sticky", 32'(err), 32'(1));
      applyStimulus('0, '0, 1'b0, 1'b1);
      checkOutput("verr_cleared", 32'(err), 32'(0));
`endif

      // Random traffic against the model
      applyStimulus('0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(NREQ'($urandom), (NREQ*DW)'($urandom),
                       ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
